// File: rtl/dual_edge_deser.sv
// Dual-edge receive deserializer: re-pairs DDR half-beats into
// wide words and queues them in a small valid/ready FIFO.
module dual_edge_deser #(
  parameter int DATA_WIDTH = 8,
  parameter int BEATS      = 2,
  parameter int FIFO_DEPTH = 4,
  parameter logic [2*DATA_WIDTH*BEATS-1:0] RESET_VALUE = '0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_WIDTH-1:0]         ddr_data,
  input  logic                          ddr_valid,
  output logic [2*DATA_WIDTH*BEATS-1:0] out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          err_align,
  output logic                          err_short,
  output logic                          err_ovf,
  input  logic                          err_clr
);

  localparam int PW = 2 * DATA_WIDTH;
  localparam int WW = PW * BEATS;
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic {
    S_IDLE,
    S_ASM
  } state_t;

  state_t                state_q;
  state_t                state_nxt;
  logic [CW-1:0]         cnt_q;
  logic [CW-1:0]         cnt_nxt;
  logic [WW-1:0]         asm_q;
  logic [WW-1:0]         asm_nxt;
  logic [WW-1:0]         word_q;
  logic                  push_q;
  logic                  done;
  logic                  set_align;
  logic                  set_short;

  logic [DATA_WIDTH-1:0] neg_data;
  logic                  neg_valid;
  logic [PW-1:0]         pair;
  logic                  pr_full;
  logic                  pr_half;
  logic                  pr_none;

  logic [WW-1:0]         mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [AW:0]           count;
  logic                  fifo_full;
  logic                  pop;
  logic                  wr_en;
  logic                  drop;

  // Negedge half arrives first, so it lands in the low bits.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      neg_data  <= '0;
      neg_valid <= 1'b0;
    end else begin
      neg_data  <= ddr_data;
      neg_valid <= ddr_valid;
    end
  end

  assign pair    = {ddr_data, neg_data};
  assign pr_full = neg_valid & ddr_valid;
  assign pr_half = neg_valid ^ ddr_valid;
  assign pr_none = ~neg_valid & ~ddr_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      asm_q   <= RESET_VALUE;
    end else begin
      state_q <= state_nxt;
      cnt_q   <= cnt_nxt;
      asm_q   <= asm_nxt;
    end
  end

  always_comb begin
    state_nxt = state_q;
    cnt_nxt   = cnt_q;
    asm_nxt   = asm_q;
    done      = 1'b0;
    set_align = 1'b0;
    set_short = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        unique case (1'b1)
          pr_full: begin
            asm_nxt[0 +: PW] = pair;
            if (BEATS == 1) begin
              done = 1'b1;
            end else begin
              state_nxt = S_ASM;
              cnt_nxt   = CW'(1);
            end
          end
          pr_half: set_align = 1'b1;
          pr_none: ;
          default: ;
        endcase
      end
      S_ASM: begin
        unique case (1'b1)
          pr_full: begin
            asm_nxt[int'(cnt_q) * PW +: PW] = pair;
            if (cnt_q == CW'(BEATS - 1)) begin
              done      = 1'b1;
              state_nxt = S_IDLE;
              cnt_nxt   = '0;
            end else begin
              cnt_nxt = cnt_q + CW'(1);
            end
          end
          pr_half: begin
            set_align = 1'b1;
            set_short = 1'b1;
            state_nxt = S_IDLE;
            cnt_nxt   = '0;
          end
          pr_none: begin
            set_short = 1'b1;
            state_nxt = S_IDLE;
            cnt_nxt   = '0;
          end
          default: ;
        endcase
      end
      default: begin
        state_nxt = S_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Completed word is staged one cycle before entering the FIFO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_q <= RESET_VALUE;
      push_q <= 1'b0;
    end else begin
      push_q <= done;
      if (done) begin
        word_q <= asm_nxt;
      end
    end
  end

  assign out_valid = (count != '0);
  assign out_data  = mem[rd_ptr];
  assign fifo_full = (count == (AW + 1)'(FIFO_DEPTH));
  assign pop       = out_valid & out_ready;
  assign wr_en     = push_q & (~fifo_full | pop);
  assign drop      = push_q & fifo_full & ~pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem[i] <= RESET_VALUE;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= word_q;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      unique case ({wr_en, pop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: ;
      endcase
    end
  end

  // A fresh error wins over a simultaneous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_align <= 1'b0;
      err_short <= 1'b0;
      err_ovf   <= 1'b0;
    end else begin
      err_align <= (err_align & ~err_clr) | set_align;
      err_short <= (err_short & ~err_clr) | set_short;
      err_ovf   <= (err_ovf & ~err_clr) | drop;
    end
  end

endmodule

// File: tb/tb_dual_edge_deser.sv
// Directed bench for dual_edge_deser: framing, FIFO
// back-pressure, error flags and mid-frame reset.
module tb_dual_edge_deser;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  ddr_data;
  logic        ddr_valid;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        err_align;
  logic        err_short;
  logic        err_ovf;
  logic        err_clr;

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  dual_edge_deser #(
    .DATA_WIDTH (8),
    .BEATS      (2),
    .FIFO_DEPTH (4),
    .RESET_VALUE(32'h0)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .ddr_data (ddr_data),
    .ddr_valid(ddr_valid),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .err_align(err_align),
    .err_short(err_short),
    .err_ovf  (err_ovf),
    .err_clr  (err_clr)
  );

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  // One half-beat for the negedge, then one for the posedge.
  task automatic send_pair(input logic nv, input logic [7:0] nd,
                           input logic pv, input logic [7:0] pd);
    @(posedge clk);
    #1;
    ddr_valid = nv;
    ddr_data  = nd;
    @(negedge clk);
    #1;
    ddr_valid = pv;
    ddr_data  = pd;
  endtask

  task automatic send_word(input logic [31:0] w);
    send_pair(1'b1, w[7:0], 1'b1, w[15:8]);
    send_pair(1'b1, w[23:16], 1'b1, w[31:24]);
  endtask

  task automatic idle_cycle();
    @(posedge clk);
    #1;
    ddr_valid = 1'b0;
    ddr_data  = 8'h00;
    @(negedge clk);
  endtask

  task automatic check_flags(input string tag,
                             input logic [2:0] exp);
    check(tag, {29'd0, err_align, err_short, err_ovf},
          {29'd0, exp});
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    ddr_data  = 8'h00;
    ddr_valid = 1'b0;
    out_ready = 1'b0;
    err_clr   = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_data", out_data, 32'd0);
    check_flags("rst_flags", 3'b000);
    rst = 1'b0;

    // Basic frame with the consumer always ready.
    out_ready = 1'b1;
    send_word(32'h4433_2211);
    idle_cycle();
    check("basic_lat0", {31'd0, out_valid}, 32'd0);
    idle_cycle();
    check("basic_valid", {31'd0, out_valid}, 32'd1);
    check("basic_data", out_data, 32'h4433_2211);
    idle_cycle();
    check("basic_pulse", {31'd0, out_valid}, 32'd0);
    check_flags("basic_flags", 3'b000);

    // Five words into a four-deep FIFO with no consumer.
    out_ready = 1'b0;
    for (int i = 1; i <= 5; i++) send_word(32'(i));
    repeat (3) idle_cycle();
    check_flags("ovf_flag", 3'b001);
    for (int i = 1; i <= 4; i++) begin
      check("ovf_valid", {31'd0, out_valid}, 32'd1);
      check("ovf_data", out_data, 32'(i));
      out_ready = 1'b1;
      @(negedge clk);
    end
    check("ovf_empty", {31'd0, out_valid}, 32'd0);
    pulse_clr();
    check_flags("ovf_clr", 3'b000);

    // Fifth word lands on the same edge as the first pop.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send_word(32'h100 + 32'(i));
    send_word(32'h104);
    idle_cycle();
    check("full_data1", out_data, 32'h100);
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      check("full_valid", {31'd0, out_valid}, 32'd1);
      check("full_data", out_data, 32'h100 + 32'(i));
    end
    @(negedge clk);
    check("full_empty", {31'd0, out_valid}, 32'd0);
    check_flags("full_flags", 3'b000);

    // Lone negedge half-beat in IDLE.
    send_pair(1'b1, 8'hAA, 1'b0, 8'h00);
    idle_cycle();
    check_flags("half_flags", 3'b100);
    check("half_nopush", {31'd0, out_valid}, 32'd0);
    send_word(32'hCAFE_BABE);
    idle_cycle();
    check("half_lat0", {31'd0, out_valid}, 32'd0);
    idle_cycle();
    check("half_valid", {31'd0, out_valid}, 32'd1);
    check("half_data", out_data, 32'hCAFE_BABE);
    idle_cycle();
    check_flags("half_after", 3'b100);
    pulse_clr();
    check_flags("half_clr", 3'b000);

    // One pair, then the lane goes quiet.
    send_pair(1'b1, 8'h55, 1'b1, 8'h66);
    idle_cycle();
    idle_cycle();
    check_flags("short_flags", 3'b010);
    idle_cycle();
    check("short_valid", {31'd0, out_valid}, 32'd0);

    // Reset with a word queued and a partial word pending.
    out_ready = 1'b0;
    send_word(32'h1234_5678);
    repeat (2) idle_cycle();
    check("mid_queued", out_data, 32'h1234_5678);
    send_pair(1'b1, 8'h77, 1'b1, 8'h88);
    idle_cycle();
    #2;
    rst = 1'b1;
    #1;
    check("mid_valid", {31'd0, out_valid}, 32'd0);
    check("mid_data", out_data, 32'd0);
    check_flags("mid_flags", 3'b000);
    @(negedge clk);
    rst = 1'b0;
    send_word(32'hDEAD_BEEF);
    repeat (2) idle_cycle();
    check("post_valid", {31'd0, out_valid}, 32'd1);
    check("post_data", out_data, 32'hDEAD_BEEF);
    out_ready = 1'b1;
    @(negedge clk);
    check("post_empty", {31'd0, out_valid}, 32'd0);
    check_flags("post_flags", 3'b000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
